// File: rtl/instr_fetch.sv
// instr_fetch: drives the instruction ROM read port and assembles 1/2/3-byte instructions for the control unit.
// Define IFETCH_ILLEGAL_TRAP_EN to trap opcodes outside the legal set (HALT with err=1).
module instr_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [7:0]  OP_LDAC = 8'd4,
  parameter logic [7:0]  OP_JPNZ = 8'd42,
  parameter logic [7:0]  OP_END  = 8'd46
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              read_IRAM,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        opcode,
  output logic [15:0]       operand,
  input  logic              zero_flag,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OPND_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_OP_RD,
    S_OP_CAP,
    S_B1_RD,
    S_B1_CAP,
    S_B2_RD,
    S_B2_CAP,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   opcode_q, opcode_d;
  logic [OPND_W-1:0]   operand_q, operand_d;
  logic                read_iram_q, read_iram_d;
  logic                instr_valid_q, instr_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   fetch_pc;

  function automatic logic is_rd(input state_e s);
    is_rd = (s == S_OP_RD) || (s == S_B1_RD) || (s == S_B2_RD);
  endfunction

`ifdef IFETCH_ILLEGAL_TRAP_EN
  function automatic logic is_legal(input logic [BYTE_W-1:0] op);
    is_legal = (op == 8'd0) || (op == 8'd4) || (op == 8'd8) || (op == 8'd11) ||
               ((op >= 8'd19) && (op <= 8'd42)) ||
               ((op >= 8'd46) && (op <= 8'd51));
  endfunction
`endif

  // Next-state logic; fetch_pc is the address the next *_RD state will present.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    done_d    = done_q;
    err_d     = err_q;
    fetch_pc  = pc_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          fetch_pc = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = S_OP_RD;
        end
      end
      S_OP_RD: state_d = S_OP_CAP;
      S_OP_CAP: begin
        opcode_d  = instr_out;
        operand_d = '0;
        if ((instr_out == OP_LDAC) || (instr_out == OP_JPNZ)) begin
          state_d = S_B1_RD;
        end
`ifdef IFETCH_ILLEGAL_TRAP_EN
        else if (!is_legal(instr_out)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end
`endif
        else begin
          state_d = S_ISSUE;
        end
      end
      S_B1_RD: state_d = S_B1_CAP;
      S_B1_CAP: begin
        operand_d[7:0] = instr_out;
        state_d        = (opcode_q == OP_LDAC) ? S_B2_RD : S_ISSUE;
      end
      S_B2_RD: state_d = S_B2_CAP;
      S_B2_CAP: begin
        operand_d[15:8] = instr_out;
        state_d         = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) begin
          if (opcode_q == OP_END) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else begin
            // Taken jpnz redirects; a fall-through keeps pc past the target byte.
            if ((opcode_q == OP_JPNZ) && !zero_flag) begin
              fetch_pc = ADDR_W'(operand_q[7:0]);
            end
            state_d = S_OP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    read_iram_d = is_rd(state_d);
    if (read_iram_d) begin
      addr_d = fetch_pc;
      pc_d   = fetch_pc + ADDR_W'(1);
    end
    instr_valid_d = (state_d == S_ISSUE);
    busy_d        = !((state_d == S_IDLE) || (state_d == S_HALT));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      addr_q        <= '0;
      opcode_q      <= '0;
      operand_q     <= '0;
      read_iram_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      read_iram_q   <= read_iram_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign read_IRAM   = read_iram_q;
  assign addr        = addr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
